// File: rtl/vio_pkg.sv
// vio_pkg: shared types and constants for the vio target block.
//   vio_op_t    - command opcodes carried in vio_din[15:12]
//   vio_state_t - command execution states
//   *_BIT       - bit positions of the status flags in vio_dout
package vio_pkg;

  typedef enum logic [3:0] {
    OP_NOP      = 4'd0,
    OP_FLASH    = 4'd1,
    OP_WAIT_VBL = 4'd2,
    OP_MEASURE  = 4'd3,
    OP_CLEAR    = 4'd4
  } vio_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    MEAS = 2'd2
  } vio_state_t;

  localparam int BUSY_BIT  = 15;
  localparam int OVF_BIT   = 14;
  localparam int TMO_BIT   = 13;
  localparam int VALID_BIT = 12;

  // A MEASURE argument of zero selects the longest possible window.
  localparam logic [11:0] LIMIT_MAX = 12'hFFF;

endpackage

// File: rtl/vio_if.sv
// vio_if: 16-bit vio word link between the CPU side (master) and the
// test-fixture target (slave).
//   vio_en     - link enable, low flushes and aborts the target
//   vio_strobe - one-cycle pulse qualifying vio_din
//   vio_din    - command word {opcode[3:0], arg[11:0]}
//   vio_dout   - status word {busy, ovf, timeout, valid, result[11:0]}
//   vio_cfg    - constant capability word
interface vio_if;
  logic        vio_en;
  logic        vio_strobe;
  logic [15:0] vio_din;
  logic [15:0] vio_dout;
  logic [15:0] vio_cfg;

  modport master (
    output vio_en, vio_strobe, vio_din,
    input  vio_dout, vio_cfg
  );

  modport slave (
    input  vio_en, vio_strobe, vio_din,
    output vio_dout, vio_cfg
  );
endinterface

// File: rtl/vio_cmd_fifo.sv
// vio_cmd_fifo: first-word-fall-through command FIFO, depth 2**AW.
//   clk, reset - clock, asynchronous active-high reset
//   flush      - synchronous empty, wins over push/pop
//   push, din  - write request and data; accepted when not full or when
//                a pop happens in the same cycle
//   pop        - discard the head word (ignored when empty)
//   dout       - head word, valid whenever empty is low
//   empty/full - occupancy flags; count - number of stored words
module vio_cmd_fifo #(
  parameter int AW = 3,
  parameter int W  = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count
);
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign dout    = mem[rd_ptr];

  // NOTE: the storage array has no reset; its contents are only read behind
  // a valid count, so resetting it would just cost flops for no behaviour.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= din;
  end

  // NOTE: sequential state is assigned with <= only, so every register sees
  // the pre-edge value of every other register regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/vio_target.sv
// vio_target: target end of the vio word link. Queues command words and
// executes them in order: drive a flash marker, wait a number of frames,
// or measure in scanlines the delay to a photo-sensor rising edge.
//   clk, reset      - clock, asynchronous active-high reset
//   bus (slave)     - vio_en / vio_strobe / vio_din in, vio_dout / vio_cfg out
//   hsync, vblank   - synchronous video timing, rising edge = line / frame
//   sensor          - asynchronous photo-sensor, active-high
//   flash           - marker drive to the video overlay
module vio_target
  import vio_pkg::*;
#(
  parameter int         FIFO_AW = 3,
  parameter logic [3:0] VERSION = 4'h1
) (
  input  logic clk,
  input  logic reset,
  vio_if.slave bus,
  input  logic hsync,
  input  logic vblank,
  input  logic sensor,
  output logic flash
);
  localparam int CW = FIFO_AW + 1;

  // Command FIFO
  logic          push, pop, flush, push_ok;
  logic          fifo_empty, fifo_full;
  logic [15:0]   fifo_dout;
  logic [CW-1:0] fifo_count, count_n;
  vio_op_t       op;
  logic [11:0]   arg;

  // Execution state and status
  vio_state_t  state, state_n;
  logic [7:0]  frames, frames_n;
  logic [11:0] limit, limit_n;
  logic [11:0] result, result_n;
  logic [11:0] result_inc;
  logic        valid, valid_n;
  logic        tmo, tmo_n;
  logic        ovf, ovf_n;
  logic        flash_n;
  logic        busy_n;
  logic [15:0] dout_q;

  // Input conditioning
  logic sens_meta, sens_sync, sens_prev, sens_rise;
  logic hs_prev, vb_prev;
  logic hs_rise, vb_rise;

  assign flush   = ~bus.vio_en;
  assign push    = bus.vio_en & bus.vio_strobe;
  assign pop     = bus.vio_en & (state == IDLE) & ~fifo_empty;
  assign push_ok = push & (~fifo_full | pop);
  assign op      = vio_op_t'(fifo_dout[15:12]);
  assign arg     = fifo_dout[11:0];

  assign bus.vio_cfg  = {VERSION, 4'(FIFO_AW), 8'h00};
  assign bus.vio_dout = dout_q;

  vio_cmd_fifo #(
    .AW (FIFO_AW),
    .W  (16)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .din   (bus.vio_din),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  // hsync/vblank are already in the clk domain, so a single history flop
  // yields a same-cycle pulse. The sensor goes through two sync stages plus
  // a registered edge, i.e. a fixed 3-cycle latency the CPU subtracts.
  assign hs_rise = hsync & ~hs_prev;
  assign vb_rise = vblank & ~vb_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sens_meta <= 1'b0;
      sens_sync <= 1'b0;
      sens_prev <= 1'b0;
      sens_rise <= 1'b0;
      hs_prev   <= 1'b0;
      vb_prev   <= 1'b0;
    end else begin
      sens_meta <= sensor;
      sens_sync <= sens_meta;
      sens_prev <= sens_sync;
      sens_rise <= sens_sync & ~sens_prev;
      hs_prev   <= hsync;
      vb_prev   <= vblank;
    end
  end

  assign result_inc = result + 12'd1;

  // NOTE: every output of this block is given its hold value first, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_n  = state;
    frames_n = frames;
    limit_n  = limit;
    result_n = result;
    valid_n  = valid;
    tmo_n    = tmo;
    ovf_n    = ovf;
    flash_n  = flash;

    if (flush) begin
      // Abort: results and sticky flags survive, the marker does not.
      state_n = IDLE;
      flash_n = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            case (op)
              OP_FLASH: flash_n = arg[0];
              OP_WAIT_VBL: begin
                frames_n = arg[7:0];
                if (arg[7:0] != 8'd0) state_n = WAIT;
              end
              OP_MEASURE: begin
                valid_n  = 1'b0;
                tmo_n    = 1'b0;
                result_n = '0;
                limit_n  = (arg == 12'd0) ? LIMIT_MAX : arg;
                state_n  = MEAS;
              end
              OP_CLEAR: begin
                ovf_n    = 1'b0;
                tmo_n    = 1'b0;
                valid_n  = 1'b0;
                result_n = '0;
              end
              default: ;
            endcase
          end
        end
        WAIT: begin
          if (vb_rise) begin
            frames_n = frames - 8'd1;
            if (frames == 8'd1) state_n = IDLE;
          end
        end
        MEAS: begin
          // The sensor edge wins over a coincident line edge.
          if (sens_rise) begin
            valid_n = 1'b1;
            state_n = IDLE;
          end else if (hs_rise) begin
            if (result_inc >= limit) begin
              result_n = limit;
              tmo_n    = 1'b1;
              valid_n  = 1'b0;
              state_n  = IDLE;
            end else begin
              result_n = result_inc;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end

    if (push & fifo_full & ~pop) ovf_n = 1'b1;

    // busy is reported from post-edge occupancy so a freshly pushed word
    // shows as busy in the very next cycle.
    count_n = flush ? '0 : (fifo_count + CW'(push_ok) - CW'(pop));
    busy_n  = (count_n != '0) | (state_n != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      frames <= '0;
      limit  <= '0;
      result <= '0;
      valid  <= 1'b0;
      tmo    <= 1'b0;
      ovf    <= 1'b0;
      flash  <= 1'b0;
      dout_q <= '0;
    end else begin
      state  <= state_n;
      frames <= frames_n;
      limit  <= limit_n;
      result <= result_n;
      valid  <= valid_n;
      tmo    <= tmo_n;
      ovf    <= ovf_n;
      flash  <= flash_n;
      dout_q[BUSY_BIT]  <= busy_n;
      dout_q[OVF_BIT]   <= ovf_n;
      dout_q[TMO_BIT]   <= tmo_n;
      dout_q[VALID_BIT] <= valid_n;
      dout_q[11:0]      <= result_n;
    end
  end
endmodule

// File: tb/tb_vio_target.sv
// tb_vio_target: self-checking bench for vio_target. Status expectations
// come from a small command-level model (sticky flags and result value);
// timing expectations come from the documented cycle offsets.
module tb_vio_target;

  logic clk = 1'b0;
  logic reset;
  logic hsync, vblank, sensor;
  logic flash;

  vio_if bus ();

  vio_target #(
    .FIFO_AW (3),
    .VERSION (4'h1)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus.slave),
    .hsync  (hsync),
    .vblank (vblank),
    .sensor (sensor),
    .flash  (flash)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Command-level model of the status register.
  bit m_ovf, m_tmo, m_valid;
  int m_result;

  function automatic logic [15:0] exp_dout(input bit busy);
    return {busy, m_ovf, m_tmo, m_valid, 12'(m_result)};
  endfunction

  function automatic void model_clear();
    m_ovf = 0; m_tmo = 0; m_valid = 0; m_result = 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // Strobe in cycle t; returns at t+1.
  task automatic send(input logic [15:0] w);
    bus.vio_strobe = 1'b1;
    bus.vio_din    = w;
    tick();
    bus.vio_strobe = 1'b0;
  endtask

  task automatic hs_pulse();
    hsync = 1'b1; tick(); hsync = 1'b0; tick();
  endtask

  task automatic vb_pulse();
    vblank = 1'b1; tick(); vblank = 1'b0; tick();
  endtask

  task automatic do_clear();
    send(16'h4000); tick(); model_clear();
  endtask

  // Returns once the target is in MEAS (the pop cycle has passed).
  task automatic start_measure(input logic [11:0] a);
    send({4'h3, a}); tick();
    m_valid = 0; m_tmo = 0; m_result = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1; idle(3); reset = 1'b0; tick();
    model_clear();
    checks++; if (bus.vio_dout !== 16'h0000) begin errors++; $display("FAIL reset_dout: got %h want %h", bus.vio_dout, 16'h0000); end
    checks++; if (flash !== 1'b0) begin errors++; $display("FAIL reset_flash: got %b want 0", flash); end
    checks++; if (bus.vio_cfg !== 16'h1300) begin errors++; $display("FAIL cfg: got %h want %h", bus.vio_cfg, 16'h1300); end
    send(16'h1001);
    checks++; if (bus.vio_dout[15] !== 1'b1) begin errors++; $display("FAIL first_busy_t1: got %b want 1", bus.vio_dout[15]); end
    tick();
    checks++; if (flash !== 1'b1) begin errors++; $display("FAIL first_flash_t2: got %b want 1", flash); end
    checks++; if (bus.vio_dout[15] !== 1'b0) begin errors++; $display("FAIL first_busy_t2: got %b want 0", bus.vio_dout[15]); end
    // Reset in the middle of a wait with a command still queued.
    send(16'h2005); send(16'h1000);
    reset = 1'b1; #1;
    checks++; if (bus.vio_dout !== 16'h0000 || flash !== 1'b0) begin errors++; $display("FAIL midop_reset: dout %h flash %b want 0000 0", bus.vio_dout, flash); end
    reset = 1'b0; idle(3);
    checks++; if (bus.vio_dout !== 16'h0000 || flash !== 1'b0) begin errors++; $display("FAIL after_reset_idle: dout %h flash %b want 0000 0", bus.vio_dout, flash); end
  endtask

  task automatic test_wait_vbl();
    send(16'h1001); tick();
    send(16'h2003); send(16'h1000); idle(3);
    checks++; if (flash !== 1'b1 || bus.vio_dout[15] !== 1'b1) begin errors++; $display("FAIL wait_hold: flash %b busy %b want 1 1", flash, bus.vio_dout[15]); end
    vb_pulse(); vb_pulse();
    checks++; if (flash !== 1'b1 || bus.vio_dout[15] !== 1'b1) begin errors++; $display("FAIL wait_2vbl: flash %b busy %b want 1 1", flash, bus.vio_dout[15]); end
    vblank = 1'b1; tick(); vblank = 1'b0;   // now in the pop cycle
    checks++; if (flash !== 1'b1) begin errors++; $display("FAIL wait_popcycle: flash %b want 1", flash); end
    tick();
    checks++; if (flash !== 1'b0 || bus.vio_dout[15] !== 1'b0) begin errors++; $display("FAIL wait_done: flash %b busy %b want 0 0", flash, bus.vio_dout[15]); end
    // A zero-frame wait retires at once, so the next FLASH follows directly.
    send(16'h2000); send(16'h1001); tick();
    checks++; if (flash !== 1'b1) begin errors++; $display("FAIL wait_zero: flash %b want 1", flash); end
  endtask

  task automatic test_measure();
    logic [15:0] exp;
    do_clear();
    start_measure(12'h000);
    repeat (37) hs_pulse();
    m_result = 37; exp = exp_dout(1);
    checks++; if (bus.vio_dout !== exp) begin errors++; $display("FAIL meas37_running: got %h want %h", bus.vio_dout, exp); end
    sensor = 1'b1; idle(5);
    m_valid = 1; exp = exp_dout(0);
    checks++; if (bus.vio_dout !== exp) begin errors++; $display("FAIL meas37_done: got %h want %h", bus.vio_dout, exp); end
    sensor = 1'b0; idle(4);
    // Sensor edge lands on the FSM in the same cycle as the 11th line edge.
    start_measure(12'h000);
    repeat (10) hs_pulse();
    sensor = 1'b1; idle(3);
    hsync = 1'b1; tick(); hsync = 1'b0; idle(4);
    m_result = 10; m_valid = 1; exp = exp_dout(0);
    checks++; if (bus.vio_dout !== exp) begin errors++; $display("FAIL meas_coincide: got %h want %h", bus.vio_dout, exp); end
    sensor = 1'b0; idle(4);
    // Timeout at a limit of 16 lines.
    start_measure(12'h010);
    repeat (15) hs_pulse();
    m_result = 15; exp = exp_dout(1);
    checks++; if (bus.vio_dout !== exp) begin errors++; $display("FAIL tmo_before: got %h want %h", bus.vio_dout, exp); end
    hs_pulse();
    m_result = 16; m_tmo = 1; exp = exp_dout(0);
    checks++; if (bus.vio_dout !== exp) begin errors++; $display("FAIL tmo_at_limit: got %h want %h", bus.vio_dout, exp); end
    sensor = 1'b1; idle(5); hs_pulse();
    checks++; if (bus.vio_dout !== exp) begin errors++; $display("FAIL tmo_after: got %h want %h", bus.vio_dout, exp); end
    sensor = 1'b0; idle(4);
    do_clear();
    checks++; if (bus.vio_dout !== 16'h0000) begin errors++; $display("FAIL clear: got %h want %h", bus.vio_dout, 16'h0000); end
    // A sensor already high on entry is not an edge.
    sensor = 1'b1; idle(4);
    start_measure(12'h000); idle(6); hs_pulse(); hs_pulse();
    m_result = 2; exp = exp_dout(1);
    checks++; if (bus.vio_dout !== exp) begin errors++; $display("FAIL sensor_high_entry: got %h want %h", bus.vio_dout, exp); end
    sensor = 1'b0; idle(4); sensor = 1'b1; idle(5);
    m_valid = 1; exp = exp_dout(0);
    checks++; if (bus.vio_dout !== exp) begin errors++; $display("FAIL sensor_high_then_edge: got %h want %h", bus.vio_dout, exp); end
    sensor = 1'b0; idle(4);
  endtask

  task automatic test_random_measure();
    for (int it = 0; it < 8; it++) begin
      int lim, n;
      logic [15:0] exp;
      lim = (it == 0) ? 1 : int'($urandom_range(1, 40));
      n   = int'($urandom_range(0, 45));
      start_measure(12'(lim));
      repeat (n) hs_pulse();
      if (n >= lim) begin
        m_tmo = 1; m_result = lim; exp = exp_dout(0);
      end else begin
        m_result = n; exp = exp_dout(1);
      end
      checks++; if (bus.vio_dout !== exp) begin errors++; $display("FAIL rnd_meas_lines lim=%0d n=%0d: got %h want %h", lim, n, bus.vio_dout, exp); end
      sensor = 1'b1; idle(5);
      if (n < lim) m_valid = 1;
      exp = exp_dout(0);
      checks++; if (bus.vio_dout !== exp) begin errors++; $display("FAIL rnd_meas_sensor lim=%0d n=%0d: got %h want %h", lim, n, bus.vio_dout, exp); end
      sensor = 1'b0; idle(4);
    end
  endtask

  task automatic test_back_to_back();
    for (int it = 0; it < 4; it++) begin
      int n;
      logic a [8];
      n = int'($urandom_range(2, 8));
      for (int i = 0; i < n; i++) a[i] = 1'($urandom);
      for (int i = 0; i < n; i++) begin
        send({15'h0800, a[i]});
        if (i >= 1) begin
          checks++; if (flash !== a[i-1]) begin errors++; $display("FAIL b2b_flash idx=%0d: got %b want %b", i-1, flash, a[i-1]); end
        end
      end
      tick();
      checks++; if (flash !== a[n-1] || bus.vio_dout[15] !== 1'b0) begin errors++; $display("FAIL b2b_last: flash %b busy %b want %b 0", flash, bus.vio_dout[15], a[n-1]); end
    end
  endtask

  task automatic test_overflow();
    logic a [9];
    logic [15:0] exp;
    do_clear();
    for (int i = 0; i < 8; i++) a[i] = 1'($urandom);
    a[8] = ~a[7];
    send(16'h2005);
    for (int i = 0; i < 9; i++) send({15'h0800, a[i]});
    m_ovf = 1; exp = exp_dout(1);
    checks++; if (bus.vio_dout !== exp) begin errors++; $display("FAIL ovf_set: got %h want %h", bus.vio_dout, exp); end
    repeat (4) vb_pulse();
    vblank = 1'b1; tick(); vblank = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++; if (flash !== a[i]) begin errors++; $display("FAIL ovf_retained idx=%0d: got %b want %b", i, flash, a[i]); end
    end
    tick();
    exp = exp_dout(0);
    checks++; if (flash !== a[7] || bus.vio_dout !== exp) begin errors++; $display("FAIL ovf_dropped: flash %b dout %h want %b %h", flash, bus.vio_dout, a[7], exp); end
    // Full FIFO in the pop cycle: the extra word is accepted, no ovf.
    do_clear();
    for (int i = 0; i < 8; i++) a[i] = 1'($urandom);
    a[8] = ~a[7];
    send(16'h2001);
    for (int i = 0; i < 8; i++) send({15'h0800, a[i]});
    vblank = 1'b1; tick(); vblank = 1'b0;
    send({15'h0800, a[8]});
    checks++; if (flash !== a[0] || bus.vio_dout[14] !== 1'b0) begin errors++; $display("FAIL pushpop_full: flash %b ovf %b want %b 0", flash, bus.vio_dout[14], a[0]); end
    for (int i = 1; i < 9; i++) begin
      tick();
      checks++; if (flash !== a[i]) begin errors++; $display("FAIL pushpop_seq idx=%0d: got %b want %b", i, flash, a[i]); end
    end
    tick();
    exp = exp_dout(0);
    checks++; if (bus.vio_dout !== exp) begin errors++; $display("FAIL pushpop_end: got %h want %h", bus.vio_dout, exp); end
  endtask

  task automatic test_flush();
    logic [15:0] exp;
    do_clear();
    send(16'h1001);
    start_measure(12'h000);
    repeat (5) hs_pulse();
    m_result = 5;
    repeat (3) send(16'h1000);
    exp = exp_dout(1);
    checks++; if (bus.vio_dout !== exp || flash !== 1'b1) begin errors++; $display("FAIL flush_pre: dout %h flash %b want %h 1", bus.vio_dout, flash, exp); end
    bus.vio_en = 1'b0; tick();
    exp = exp_dout(0);
    checks++; if (bus.vio_dout !== exp || flash !== 1'b0) begin errors++; $display("FAIL flush_next: dout %h flash %b want %h 0", bus.vio_dout, flash, exp); end
    send(16'h1001); send(16'h1001);
    checks++; if (bus.vio_dout !== exp || flash !== 1'b0) begin errors++; $display("FAIL flush_strobe_ignored: dout %h flash %b want %h 0", bus.vio_dout, flash, exp); end
    bus.vio_en = 1'b1; tick();
    checks++; if (bus.vio_dout !== exp || flash !== 1'b0) begin errors++; $display("FAIL flush_reenable: dout %h flash %b want %h 0", bus.vio_dout, flash, exp); end
    send(16'h1001); tick();
    checks++; if (flash !== 1'b1) begin errors++; $display("FAIL flush_resume: flash %b want 1", flash); end
    // Sticky ovf and partial result survive a flush.
    start_measure(12'h000);
    repeat (3) hs_pulse();
    m_result = 3;
    repeat (9) send(16'h1000);
    m_ovf = 1; exp = exp_dout(1);
    checks++; if (bus.vio_dout !== exp) begin errors++; $display("FAIL flush_ovf_pre: got %h want %h", bus.vio_dout, exp); end
    bus.vio_en = 1'b0; tick(); bus.vio_en = 1'b1; tick();
    exp = exp_dout(0);
    checks++; if (bus.vio_dout !== exp || flash !== 1'b0) begin errors++; $display("FAIL flush_ovf_kept: dout %h flash %b want %h 0", bus.vio_dout, flash, exp); end
    do_clear();
    checks++; if (bus.vio_dout !== 16'h0000) begin errors++; $display("FAIL flush_final_clear: got %h want %h", bus.vio_dout, 16'h0000); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    hsync          = 1'b0;
    vblank         = 1'b0;
    sensor         = 1'b0;
    bus.vio_en     = 1'b1;
    bus.vio_strobe = 1'b0;
    bus.vio_din    = 16'h0000;
    model_clear();
    test_reset();
    test_wait_vbl();
    test_measure();
    test_random_measure();
    test_back_to_back();
    test_overflow();
    test_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
